// File: rtl/video_timing_gen.sv
// Runtime-programmable raster timing generator with frame-boundary shadowing of timing registers.
// Counters, syncs and strobes update together; blanking lags the counters by one clock.
module video_timing_gen #(
  parameter int unsigned HW           = 13,
  parameter int unsigned VW           = 10,
  parameter int unsigned DEF_H_TOTAL  = 1920,
  parameter int unsigned DEF_H_START  = 368,
  parameter int unsigned DEF_H_ACTIVE = 1440,
  parameter int unsigned DEF_H_SYNC   = 144,
  parameter int unsigned DEF_V_TOTAL  = 312,
  parameter int unsigned DEF_V_START  = 26,
  parameter int unsigned DEF_V_ACTIVE = 280,
  parameter int unsigned DEF_V_SYNC   = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic [3:0]    cfg_addr,
  input  logic [HW-1:0] cfg_wdata,
  output logic [HW-1:0] cfg_rdata,
  output logic          cfg_pending,
  input  logic          sm,
  input  logic [1:0]    pix_div,
  output logic [HW-1:0] video_x,
  output logic [VW-1:0] video_y,
  output logic          hsync,
  output logic          vsync,
  output logic          hblank,
  output logic          vblank,
  output logic          parity,
  output logic          field_toggle,
  output logic          new_line,
  output logic          new_frame,
  output logic          pix_strobe,
  output logic          line_irq
);

  // Register index within each group: 0 total, 1 start, 2 active, 3 sync.
  logic [HW-1:0] h_pend_q [4];
  logic [HW-1:0] h_pend_d [4];
  logic [HW-1:0] h_act_q  [4];
  logic [HW-1:0] h_act_d  [4];
  logic [VW-1:0] v_pend_q [4];
  logic [VW-1:0] v_pend_d [4];
  logic [VW-1:0] v_act_q  [4];
  logic [VW-1:0] v_act_d  [4];
  logic [VW-1:0] irq_q, irq_d;

  logic [HW-1:0] x_q, x_d;
  logic [VW-1:0] y_q, y_d;
  logic          parity_q, parity_d;
  logic          ft_q, ft_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          hblank_q, hblank_d;
  logic          vblank_q, vblank_d;
  logic          new_line_q, new_line_d;
  logic          new_frame_q, new_frame_d;
  logic          line_irq_q, line_irq_d;

  logic [HW-1:0] ht_eff, ht_half;
  logic [VW-1:0] vt_eff, field_last;
  logic          wrap, field_end, frame_end;
  logic [HW:0]   h_lo, h_hi;
  logic [VW:0]   v_lo, v_hi;
  logic          pix_phase;

  // Undersized totals are clamped at use so readback still shows the written value.
  assign ht_eff     = (h_act_q[0] < HW'(4)) ? HW'(4) : h_act_q[0];
  assign vt_eff     = (v_act_q[0] < VW'(2)) ? VW'(2) : v_act_q[0];
  assign ht_half    = ht_eff >> 1;
  assign wrap       = (x_q >= ht_eff - HW'(1));
  // The even interlaced field carries one extra line.
  assign field_last = (sm && !parity_q) ? vt_eff : vt_eff - VW'(1);
  assign field_end  = wrap && (y_q >= field_last);
  assign frame_end  = field_end && parity_d;

  assign h_lo = {1'b0, h_act_q[1]};
  assign h_hi = h_lo + {1'b0, h_act_q[2]};
  assign v_lo = {1'b0, v_act_q[1]} + {{VW{1'b0}}, ~parity_q};
  assign v_hi = v_lo + {1'b0, v_act_q[2]};

  always_comb begin
    x_d         = wrap ? '0 : x_q + HW'(1);
    y_d         = y_q;
    parity_d    = parity_q;
    ft_d        = ft_q;
    if (field_end) begin
      y_d      = '0;
      parity_d = sm ? ~parity_q : 1'b1;
      ft_d     = ~ft_q;
    end else if (wrap) begin
      y_d = y_q + VW'(1);
    end

    hsync_d = hsync_q;
    if (wrap) begin
      hsync_d = 1'b1;
    end else if (x_d == h_act_q[3]) begin
      hsync_d = 1'b0;
    end

    // Even field sync edges sit half a line in, giving the interlace offset.
    vsync_d = vsync_q;
    if (frame_end) begin
      vsync_d = 1'b1;
    end else if (parity_d) begin
      if (wrap && (y_d == v_act_q[3])) vsync_d = 1'b0;
    end else if (x_d == ht_half) begin
      if (y_d == '0) begin
        vsync_d = 1'b1;
      end else if (y_d == v_act_q[3]) begin
        vsync_d = 1'b0;
      end
    end

    hblank_d    = !(({1'b0, x_q} >= h_lo) && ({1'b0, x_q} < h_hi));
    vblank_d    = !(({1'b0, y_q} >= v_lo) && ({1'b0, y_q} < v_hi));
    new_line_d  = wrap;
    new_frame_d = frame_end;
    line_irq_d  = wrap && (y_d == irq_q);
  end

  always_comb begin
    h_pend_d = h_pend_q;
    v_pend_d = v_pend_q;
    h_act_d  = h_act_q;
    v_act_d  = v_act_q;
    irq_d    = irq_q;
    if (frame_end) begin
      h_act_d = h_pend_q;
      v_act_d = v_pend_q;
    end
    // A write on the boundary cycle lands in pending only.
    if (cfg_we) begin
      if (cfg_addr < 4'd4) begin
        h_pend_d[cfg_addr[1:0]] = cfg_wdata;
      end else if (cfg_addr < 4'd8) begin
        v_pend_d[cfg_addr[1:0]] = cfg_wdata[VW-1:0];
      end else if (cfg_addr == 4'd8) begin
        irq_d = cfg_wdata[VW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_pend_q[0] <= HW'(DEF_H_TOTAL);
      h_pend_q[1] <= HW'(DEF_H_START);
      h_pend_q[2] <= HW'(DEF_H_ACTIVE);
      h_pend_q[3] <= HW'(DEF_H_SYNC);
      h_act_q[0]  <= HW'(DEF_H_TOTAL);
      h_act_q[1]  <= HW'(DEF_H_START);
      h_act_q[2]  <= HW'(DEF_H_ACTIVE);
      h_act_q[3]  <= HW'(DEF_H_SYNC);
      v_pend_q[0] <= VW'(DEF_V_TOTAL);
      v_pend_q[1] <= VW'(DEF_V_START);
      v_pend_q[2] <= VW'(DEF_V_ACTIVE);
      v_pend_q[3] <= VW'(DEF_V_SYNC);
      v_act_q[0]  <= VW'(DEF_V_TOTAL);
      v_act_q[1]  <= VW'(DEF_V_START);
      v_act_q[2]  <= VW'(DEF_V_ACTIVE);
      v_act_q[3]  <= VW'(DEF_V_SYNC);
      irq_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      parity_q    <= 1'b1;
      ft_q        <= 1'b1;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      hblank_q    <= 1'b1;
      vblank_q    <= 1'b1;
      new_line_q  <= 1'b0;
      new_frame_q <= 1'b0;
      line_irq_q  <= 1'b0;
    end else begin
      h_pend_q    <= h_pend_d;
      h_act_q     <= h_act_d;
      v_pend_q    <= v_pend_d;
      v_act_q     <= v_act_d;
      irq_q       <= irq_d;
      x_q         <= x_d;
      y_q         <= y_d;
      parity_q    <= parity_d;
      ft_q        <= ft_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      hblank_q    <= hblank_d;
      vblank_q    <= vblank_d;
      new_line_q  <= new_line_d;
      new_frame_q <= new_frame_d;
      line_irq_q  <= line_irq_d;
    end
  end

  always_comb begin
    cfg_pending = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ((h_pend_q[i] != h_act_q[i]) || (v_pend_q[i] != v_act_q[i])) cfg_pending = 1'b1;
    end
  end

  always_comb begin
    cfg_rdata = '0;
    if (cfg_addr < 4'd4) begin
      cfg_rdata = h_pend_q[cfg_addr[1:0]];
    end else if (cfg_addr < 4'd8) begin
      cfg_rdata = HW'(v_pend_q[cfg_addr[1:0]]);
    end else if (cfg_addr == 4'd8) begin
      cfg_rdata = HW'(irq_q);
    end
  end

  always_comb begin
    unique case (pix_div)
      2'd0:    pix_phase = 1'b1;
      2'd1:    pix_phase = x_q[0];
      2'd2:    pix_phase = (x_q[1:0] == 2'b01);
      default: pix_phase = (x_q[2:0] == 3'b001);
    endcase
  end

  assign pix_strobe   = !hblank_q && !vblank_q && pix_phase;
  assign video_x      = x_q;
  assign video_y      = y_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign hblank       = hblank_q;
  assign vblank       = vblank_q;
  assign parity       = parity_q;
  assign field_toggle = ft_q;
  assign new_line     = new_line_q;
  assign new_frame    = new_frame_q;
  assign line_irq     = line_irq_q;

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Runtime-programmable raster timing generator; next generation of the fixed-table MCD212 video timing block.
- Horizontal and vertical parameters are loaded through a small register port into a pending set. The pending set is copied to the active set only at a frame boundary, so a running raster is never torn.
- Adds parametrised counter widths, a selectable pixel-strobe divider and a line-compare interrupt.
- Sits between the CPU register interface and the display/pixel pipeline.

Parameters:
- HW, 13, width of horizontal counter and horizontal timing registers
- VW, 10, width of vertical counter and vertical timing registers
- DEF_H_TOTAL, 1920, reset value of h_total (clocks per line)
- DEF_H_START, 368, reset value of h_start (first active clock)
- DEF_H_ACTIVE, 1440, reset value of h_active (active clocks)
- DEF_H_SYNC, 144, reset value of h_sync (hsync width in clocks)
- DEF_V_TOTAL, 312, reset value of v_total (lines per odd/progressive field)
- DEF_V_START, 26, reset value of v_start
- DEF_V_ACTIVE, 280, reset value of v_active
- DEF_V_SYNC, 3, reset value of v_sync (vsync width in lines)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cfg_we  in  1  write strobe, one write per asserted cycle
- cfg_addr  in  4  register select: 0 h_total, 1 h_start, 2 h_active, 3 h_sync, 4 v_total, 5 v_start, 6 v_active, 7 v_sync, 8 irq_line; 9–15 ignored
- cfg_wdata  in  HW  write data; vertical registers use bits [VW-1:0]
- cfg_rdata  out  HW  combinational readback of the pending register at cfg_addr; 0 for unused addresses
- cfg_pending  out  1  pending set differs from active set (write not yet applied)
- sm  in  1  scan mode: 1 interlaced, 0 progressive
- pix_div  in  2  clocks per pixel = 2^pix_div
- video_x  out  HW  horizontal clock counter
- video_y  out  VW  line counter within the field
- hsync, vsync, hblank, vblank  out  1 each  raster controls
- parity  out  1  1 for odd/progressive field, 0 for even field
- field_toggle  out  1  inverts on every field end
- new_line, new_frame, pix_strobe, line_irq  out  1 each  single-cycle strobes

Behaviour:
Reset
- Pending and active sets load the DEF_* values; irq_line = 0.
- video_x = 0, video_y = 0, parity = 1, field_toggle = 1.
- hsync = 0, vsync = 0, hblank = 1, vblank = 1, all strobes 0, cfg_pending = 0.
- A reset asserted mid-frame discards all pending writes.

Horizontal counting
- video_x counts 0..h_total-1, then wraps to 0.
- On the wrap cycle: new_line pulses and hsync is set to 1.
- hsync clears when video_x == h_sync.

Vertical counting, progressive (sm = 0)
- When video_y == v_total-1 at the x-wrap: video_y goes to 0, vsync is set, field_toggle inverts.

Vertical counting, interlaced (sm = 1)
- Odd field (parity = 1) ends at video_y == v_total-1: parity goes to 0, field_toggle inverts, vsync is not set at the line start.
- Even field (parity = 0) ends at video_y == v_total (v_total+1 lines): parity goes to 1, vsync is set.
- During the even field, vsync is set at video_x == h_total>>1 on line 0 and cleared at video_x == h_total>>1 on line v_sync. This gives the half-line offset.

vsync clear (odd/progressive)
- With parity = 1, vsync clears when video_y == v_sync.

Frame boundary
- Defined as the x-wrap cycle on which parity becomes or stays 1 and video_y goes to 0.
- On that cycle, new_frame pulses and pending is copied to active. The new values govern from the next cycle.
- cfg_pending drops on the same edge.
- A cfg_we in that same cycle lands in pending only, is not applied, and keeps cfg_pending = 1.

Configuration writes
- Take effect in the pending set on the next edge.
- Writes to irq_line apply immediately; irq_line has no shadow copy.

Blanking (registered, one cycle behind the counters)
- hblank = !(h_start <= video_x < h_start+h_active).
- vblank = !(v_start+e <= video_y < v_start+e+v_active), where e = 1 when parity = 0, else 0.
- Comparisons are done at HW+1 / VW+1 bits, so sums never wrap.

Strobes
- pix_strobe = !hblank && !vblank && (pix_div == 0 || video_x[pix_div-1:0] == 1).
- line_irq pulses on the x-wrap cycle whose next video_y equals irq_line.

Illegal programming
- Values with h_total < 4 or v_total < 2 are applied as 4 and 2 respectively.

Test Plan:
1. Reset, then program h_total = 20, h_start = 4, h_active = 12, h_sync = 2, v_total = 10, v_start = 2, v_active = 6, v_sync = 1 (sm = 0) -> cfg_pending = 1 until the first frame boundary. After it: new_line every 20 clocks; hsync high for x = 0..1; hblank low for x = 4..15, seen one cycle late; new_frame every 200 clocks.
2. Same config, sm = 1 -> fields alternate 10 and 11 lines; parity toggles. Even-field vsync rises at x = 10 of line 0 and falls at x = 10 of line 1. Active lines are 2..7 in the odd field and 3..8 in the even field.
3. pix_div = 2 -> pix_strobe only at x = 5, 9, 13 inside active lines. pix_div = 0 -> strobe on all 12 active clocks.
4. Write h_total = 30 mid-frame -> line length stays 20 until the frame boundary, then becomes 30. cfg_rdata(0) = 30 immediately. A write issued on the boundary cycle stays pending.
5. irq_line = 3 -> exactly one line_irq per field, on the wrap cycle entering line 3. Write irq_line = 9 while on line 2 -> line_irq fires entering line 9.
6. Assert reset mid-line with a write pending -> next cycle all outputs are at their reset values, and h_total reads back DEF_H_TOTAL = 1920.
